dmem_resp: RTL and testbench

- Data-memory responder for the core's load/store interface. It is the memory end of the store/load requests that the execute stage issues.
- Stores are posted into a small write buffer and then drained into a single-port synchronous SRAM using per-byte write enables.
- Loads are served with a 1-cycle latency. Bytes still pending in the buffer are forwarded into the load data.
- Stalls the pipeline through the ctrl hold path when the SRAM port or the buffer cannot accept a request.

---
 rtl/dmem_resp_pkg.sv | 24 ++
 rtl/dmem_wbuf.sv | 76 +++++++
 rtl/dmem_resp.sv | 126 ++++++++++++
 tb/tb_dmem_resp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared widths, write-buffer entry layout and the byte-lane merge helper
// for the data-memory responder.
package dmem_resp_pkg;

  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DATA_W = 32;

  // Entry layout, LSB first: {addr, data, sel}
  localparam int unsigned ENT_SEL_OFF  = 0;
  localparam int unsigned ENT_DATA_OFF = ENT_SEL_OFF + SEL_W;
  localparam int unsigned ENT_ADDR_OFF = ENT_DATA_OFF + DATA_W;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                               input logic [DATA_W-1:0] new_word,
                                               input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int unsigned k = 0; k < SEL_W; k++) begin
      if (sel[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-store FIFO with a per-lane youngest-match lookup used to forward
// still-buffered bytes into loads.
module dmem_wbuf
  import dmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [SEL_W-1:0]  push_sel,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [SEL_W-1:0]  head_sel,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [SEL_W-1:0]  fwd_mask
);

  localparam int unsigned IDX_W = $clog2(WB_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned ENT_W = ENT_ADDR_OFF + ADDR_W;

  logic [ENT_W-1:0] mem [WB_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] count;
  logic [ENT_W-1:0] head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[IDX_W] != rptr[IDX_W]) && (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign count = wptr - rptr;

  assign head      = mem[rptr[IDX_W-1:0]];
  assign head_addr = head[ENT_ADDR_OFF +: ADDR_W];
  assign head_sel  = head[ENT_SEL_OFF +: SEL_W];
  assign head_data = head[ENT_DATA_OFF +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
    end
  end

  // Storage is not reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wptr[IDX_W-1:0]] <= {push_addr, push_data, push_sel};
  end

  // Walk oldest to youngest so the youngest matching lane overwrites older ones.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      logic [IDX_W-1:0] idx;
      logic [ENT_W-1:0] ent;
      idx = rptr[IDX_W-1:0] + IDX_W'(i);
      ent = mem[idx];
      if ((PTR_W'(i) < count) && (ent[ENT_ADDR_OFF +: ADDR_W] == lookup_addr)) begin
        fwd_data = merge(fwd_data, ent[ENT_DATA_OFF +: DATA_W], ent[ENT_SEL_OFF +: SEL_W]);
        fwd_mask = fwd_mask | ent[ENT_SEL_OFF +: SEL_W];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: posts stores into a write buffer, arbitrates the
// single SRAM port between loads and drains, and returns forwarded load data.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr_req_i,
  input  logic [SEL_W-1:0]  mem_wr_sel_i,
  input  logic [31:0]       mem_wr_addr_i,
  input  logic [DATA_W-1:0] mem_wr_data_i,
  input  logic              mem_rd_req_i,
  input  logic [31:0]       mem_rd_addr_i,
  output logic [DATA_W-1:0] mem_rd_data_o,
  output logic              mem_rd_valid_o,
  output logic              hold_flag_o,
  output logic              ram_en_o,
  output logic [SEL_W-1:0]  ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  logic              wb_full;
  logic              wb_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [SEL_W-1:0]  head_sel;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] fwd_data;
  logic [SEL_W-1:0]  fwd_mask;

  logic              wr_valid;
  logic              drain;
  logic              rd_issue;
  logic              push;
  logic [ADDR_W-1:0] wr_word;
  logic [ADDR_W-1:0] rd_word;

  logic              valid_q;
  logic [DATA_W-1:0] fwd_q;
  logic [SEL_W-1:0]  mask_q;
  logic [DATA_W-1:0] last_q;
  logic [DATA_W-1:0] merged;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_wr_addr_i[31:ADDR_W+2], mem_wr_addr_i[1:0],
                              mem_rd_addr_i[31:ADDR_W+2], mem_rd_addr_i[1:0]};

  assign wr_word  = mem_wr_addr_i[ADDR_W+1:2];
  assign rd_word  = mem_rd_addr_i[ADDR_W+1:2];
  assign wr_valid = mem_wr_req_i && (mem_wr_sel_i != '0);

  // Port arbitration: forced drain when full, then load, then idle drain.
  always_comb begin
    drain       = 1'b0;
    rd_issue    = 1'b0;
    hold_flag_o = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (rst) begin
      if (wb_full)           drain    = 1'b1;
      else if (mem_rd_req_i) rd_issue = 1'b1;
      else if (!wb_empty)    drain    = 1'b1;

      hold_flag_o = (mem_rd_req_i && wb_full) || (wr_valid && wb_full && !drain);
      ram_en_o    = drain || rd_issue;
      if (drain) begin
        ram_we_o    = head_sel;
        ram_addr_o  = head_addr;
        ram_wdata_o = head_data;
      end else if (rd_issue) begin
        ram_addr_o  = rd_word;
      end
    end
  end

  assign push = rst && wr_valid && (!wb_full || drain);

  dmem_wbuf #(
    .ADDR_W  (ADDR_W),
    .WB_DEPTH(WB_DEPTH)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (wr_word),
    .push_sel   (mem_wr_sel_i),
    .push_data  (mem_wr_data_i),
    .pop        (drain),
    .full       (wb_full),
    .empty      (wb_empty),
    .head_addr  (head_addr),
    .head_sel   (head_sel),
    .head_data  (head_data),
    .lookup_addr(rd_word),
    .fwd_data   (fwd_data),
    .fwd_mask   (fwd_mask)
  );

  // Read-return: forwarding captured at issue, SRAM data arrives one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      fwd_q   <= '0;
      mask_q  <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= rd_issue;
      if (rd_issue) begin
        fwd_q  <= fwd_data;
        mask_q <= fwd_mask;
      end
      if (valid_q) last_q <= merged;
    end
  end

  assign merged         = merge(ram_rdata_i, fwd_q, mask_q);
  assign mem_rd_valid_o = valid_q && rst;
  assign mem_rd_data_o  = mem_rd_valid_o ? merged : last_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a byte-level memory model predicts load data,
// a pending-store queue predicts drains and holds, and a monitor checks returns.
module tb_dmem_resp;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned WB_DEPTH = 2;
  localparam int unsigned NWORDS   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_wr_req_i;
  logic [3:0]        mem_wr_sel_i;
  logic [31:0]       mem_wr_addr_i;
  logic [31:0]       mem_wr_data_i;
  logic              mem_rd_req_i;
  logic [31:0]       mem_rd_addr_i;
  logic [31:0]       mem_rd_data_o;
  logic              mem_rd_valid_o;
  logic              hold_flag_o;
  logic              ram_en_o;
  logic [3:0]        ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [3:0]        s;
    logic [31:0]       d;
  } st_t;

  st_t         pending[$];
  logic [31:0] exp_q[$];
  logic [31:0] sram [NWORDS] = '{default: 32'h0};
  logic [31:0] arch [NWORDS];
  logic [31:0] last_ret = 32'h0;
  logic [31:0] ret_e;
  logic        last_hold = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wr_req_i  (mem_wr_req_i),
    .mem_wr_sel_i  (mem_wr_sel_i),
    .mem_wr_addr_i (mem_wr_addr_i),
    .mem_wr_data_i (mem_wr_data_i),
    .mem_rd_req_i  (mem_rd_req_i),
    .mem_rd_addr_i (mem_rd_addr_i),
    .mem_rd_data_o (mem_rd_data_o),
    .mem_rd_valid_o(mem_rd_valid_o),
    .hold_flag_o   (hold_flag_o),
    .ram_en_o      (ram_en_o),
    .ram_we_o      (ram_we_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_rdata_i   (ram_rdata)
  );

  // Behavioural single-port SRAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o == 4'b0000) ram_rdata <= sram[ram_addr_o];
      else
        for (int k = 0; k < 4; k++)
          if (ram_we_o[k]) sram[ram_addr_o][8*k +: 8] <= ram_wdata_o[8*k +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  // Monitor: compare every returned load against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      last_ret = 32'h0;
      chk("valid_in_reset", 32'(mem_rd_valid_o), 32'h0);
    end else if (mem_rd_valid_o) begin
      if (exp_q.size() == 0) chk("unexpected_load_return", 32'h1, 32'h0);
      else begin
        ret_e = exp_q.pop_front();
        chk("load_data", mem_rd_data_o, ret_e);
        last_ret = ret_e;
      end
    end else begin
      chk("data_hold", mem_rd_data_o, last_ret);
    end
  end

  // One cycle of stimulus; called at posedge+1, checks port use mid-cycle.
  task automatic step(input logic wr, input logic [3:0] sel, input logic [31:0] waddr,
                      input logic [31:0] wdata, input logic rd, input logic [31:0] raddr,
                      input logic rv);
    logic exp_hold, exp_drain;
    st_t h;
    logic [ADDR_W-1:0] rw;
    mem_wr_req_i = wr;  mem_wr_sel_i = sel; mem_wr_addr_i = waddr; mem_wr_data_i = wdata;
    mem_rd_req_i = rd;  mem_rd_addr_i = raddr; rst = rv;
    #2;
    if (!rv) begin
      chk("ram_en_in_reset", 32'(ram_en_o), 32'h0);
      chk("hold_in_reset", 32'(hold_flag_o), 32'h0);
      pending.delete();
      exp_q.delete();
      for (int i = 0; i < NWORDS; i++) arch[i] = sram[i];
      last_hold = 1'b0;
    end else begin
      exp_hold  = rd && (pending.size() == WB_DEPTH);
      exp_drain = (pending.size() == WB_DEPTH) || (!rd && pending.size() != 0);
      chk("hold_flag", 32'(hold_flag_o), 32'(exp_hold));
      if (exp_drain) begin
        h = pending.pop_front();
        chk("drain_en", 32'(ram_en_o), 32'h1);
        chk("drain_we", 32'(ram_we_o), 32'(h.s));
        chk("drain_addr", 32'(ram_addr_o), 32'(h.a));
        chk("drain_wdata", ram_wdata_o, h.d);
      end else if (rd) begin
        chk("read_en", 32'(ram_en_o), 32'h1);
        chk("read_we", 32'(ram_we_o), 32'h0);
        chk("read_addr", 32'(ram_addr_o), 32'(raddr[ADDR_W+1:2]));
      end else begin
        chk("idle_en", 32'(ram_en_o), 32'h0);
        chk("idle_we", 32'(ram_we_o), 32'h0);
      end
      if (rd && !exp_hold) exp_q.push_back(arch[raddr[ADDR_W+1:2]]);
      if (wr && sel != 4'b0000) begin
        rw = waddr[ADDR_W+1:2];
        arch[rw] = bmerge(arch[rw], wdata, sel);
        pending.push_back('{a: rw, s: sel, d: wdata});
      end
      last_hold = exp_hold;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] ra, wa;
    for (int i = 0; i < NWORDS; i++) arch[i] = 32'h0;

    // Reset state
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("rst_valid", 32'(mem_rd_valid_o), 32'h0);
    chk("rst_data", mem_rd_data_o, 32'h0);
    chk("rst_hold", 32'(hold_flag_o), 32'h0);
    chk("rst_ram_en", 32'(ram_en_o), 32'h0);

    // Basic round trip
    step(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    #1;
    chk("t1_we", 32'(ram_we_o), 32'hF);
    chk("t1_addr", 32'(ram_addr_o), 32'h4);
    idle(1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b1);
    idle(2);

    // Single-byte forwarding over a preloaded word
    step(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 32'h0, 1'b1);
    idle(1);
    step(1'b1, 4'b0010, 32'h21, 32'h0000AB00, 1'b0, 32'h0, 1'b1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b1);
    idle(2);

    // Youngest-wins merge
    step(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 32'h0, 1'b1);
    idle(1);
    step(1'b1, 4'b0011, 32'h20, 32'h0000AAAA, 1'b1, 32'h100, 1'b1);
    step(1'b1, 4'b0001, 32'h22, 32'h000000BB, 1'b1, 32'h104, 1'b1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b1);
    idle(3);

    // Full buffer with continuous loads and three stores
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'hF, 32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i), 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h44, 1'b1);
    idle(3);

    // Reset with two entries buffered and a load in flight
    step(1'b1, 4'hF, 32'h60, 32'h12345678, 1'b1, 32'h64, 1'b1);
    step(1'b1, 4'hF, 32'h64, 32'h9ABCDEF0, 1'b1, 32'h60, 1'b1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("t5_valid", 32'(mem_rd_valid_o), 32'h0);
    chk("t5_data", mem_rd_data_o, 32'h0);
    idle(3);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h60, 1'b1);
    idle(2);

    // Zero-sel store is dropped
    step(1'b1, 4'h0, 32'h80, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    idle(2);

    // Randomized traffic over a small window with junk upper/low address bits
    for (int i = 0; i < 500; i++) begin
      wa = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(8, 15)) << 2);
      if (last_hold) begin
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, ra, 1'b1);
      end else begin
        ra = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(8, 15)) << 2);
        step(1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), wa, $urandom,
             1'($urandom_range(0, 9) < 6), ra, 1'b1);
      end
    end
    idle(6);

    chk("final_pending_empty", 32'(pending.size()), 32'h0);
    chk("final_loads_returned", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 40; i++) chk("final_sram", sram[i], arch[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
